// File: rtl/simon_sequence_player.sv
// Simon Says transmitter: plays an LFSR-generated 2-bit symbol sequence on four
// one-hot LEDs and regenerates the same stream, one symbol at a time, for the checker.
module simon_sequence_player #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       new_game,
  input  logic       start,
  input  logic [5:0] seq_len,
  input  logic       chk_restart,
  input  logic       chk_next,
  output logic [3:0] led_out,
  output logic [1:0] sym_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] exp_sym
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(ON_CYCLES - 1);
  localparam logic [7:0]    SEED_INIT = 8'h01;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_FIN} state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  state_t        r_state;
  logic [7:0]    r_seed;
  logic [7:0]    r_entropy;
  logic [7:0]    r_play_lfsr;
  logic [7:0]    r_chk_lfsr;
  logic [5:0]    r_len;
  logic [5:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_led;
  logic [1:0]    r_sym;
  logic [1:0]    r_exp_sym;
  logic          r_busy;
  logic          r_done;

  logic [7:0] w_new_seed;
  logic [7:0] w_chk_base;
  logic [7:0] w_chk_restart_val;
  logic [7:0] w_chk_next_val;
  logic [7:0] w_play_next;
  logic       w_last_sym;

  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  assign w_new_seed        = (r_entropy == 8'h00) ? SEED_INIT : r_entropy;
  assign w_chk_base        = new_game ? w_new_seed : r_seed;
  assign w_chk_restart_val = lfsr_step(w_chk_base);
  assign w_chk_next_val    = lfsr_step(r_chk_lfsr);
  assign w_play_next       = lfsr_step(r_play_lfsr);
  assign w_last_sym        = (r_idx + 6'd1) == r_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seed      <= SEED_INIT;
      r_entropy   <= SEED_INIT;
      r_play_lfsr <= SEED_INIT;
      r_chk_lfsr  <= SEED_INIT;
      r_len       <= 6'd0;
      r_idx       <= 6'd0;
      r_cnt       <= '0;
      r_led       <= 4'd0;
      r_sym       <= 2'd0;
      r_exp_sym   <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (ena) begin
      r_entropy <= lfsr_step(r_entropy);
      r_done    <= 1'b0;

      if (new_game || chk_restart) begin
        r_chk_lfsr <= w_chk_restart_val;
        r_exp_sym  <= w_chk_restart_val[1:0];
      end else if (chk_next) begin
        r_chk_lfsr <= w_chk_next_val;
        r_exp_sym  <= w_chk_next_val[1:0];
      end

      if (new_game) begin
        r_seed  <= w_new_seed;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_led   <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_len       <= seq_len;
              r_idx       <= 6'd0;
              r_play_lfsr <= r_seed;
              r_cnt       <= '0;
              if (seq_len != 6'd0) begin
                r_busy  <= 1'b1;
                r_state <= S_GAP;
              end else begin
                r_state <= S_FIN;
              end
            end
          end
          S_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt       <= '0;
              r_play_lfsr <= w_play_next;
              r_sym       <= w_play_next[1:0];
              r_led       <= 4'b0001 << w_play_next[1:0];
              r_state     <= S_SHOW;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_SHOW: begin
            if (r_cnt == SHOW_LAST) begin
              r_cnt   <= '0;
              r_led   <= 4'd0;
              r_idx   <= r_idx + 6'd1;
              r_state <= w_last_sym ? S_FIN : S_GAP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_FIN: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign led_out = r_led;
  assign sym_out = r_sym;
  assign busy    = r_busy;
  assign done    = r_done;
  assign exp_sym = r_exp_sym;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench for simon_sequence_player: expected LED symbols are queued at
// start time and popped by a monitor as each LED lights.
module tb_simon_sequence_player;

  localparam int ON  = 8;
  localparam int OFF = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, new_game, start, chk_restart, chk_next;
  logic [5:0] seq_len;
  logic [3:0] led_out;
  logic [1:0] sym_out, exp_sym;
  logic       busy, done;

  always #5 clk = ~clk;

  simon_sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .new_game(new_game), .start(start),
    .seq_len(seq_len), .chk_restart(chk_restart), .chk_next(chk_next),
    .led_out(led_out), .sym_out(sym_out), .busy(busy), .done(done), .exp_sym(exp_sym)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] led;
    logic [1:0] sym;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [7:0] m_step(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [1:0] sym_at(input logic [7:0] seed, input int n);
    logic [7:0] x = seed;
    for (int i = 0; i <= n; i++) x = m_step(x);
    return x[1:0];
  endfunction

  // Reference seed/entropy tracking, driven only by the bench's own stimulus.
  logic [7:0] ent_m  = 8'h01;
  logic [7:0] seed_m = 8'h01;
  logic       ena_q  = 1'b0;
  int         ncyc   = 0;
  always @(posedge clk) begin
    ncyc++;
    ena_q = ena;
    if (!rst_n) begin
      ent_m  = 8'h01;
      seed_m = 8'h01;
    end else if (ena) begin
      if (new_game) seed_m = (ent_m == 8'h00) ? 8'h01 : ent_m;
      ent_m = m_step(ent_m);
    end
  end

  // Monitor: pops one expected symbol per LED rise, checks dark gap and on-time.
  int         on_cnt   = 0;
  int         gap_cnt  = 0;
  logic [3:0] prev_led = 4'd0;
  always @(negedge clk) begin
    if (led_out != 4'd0 && prev_led == 4'd0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL led_unexpected: led_out=%b lit with no symbol queued", led_out);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] symbol led=%b sym=%0d (want led=%b sym=%0d)", led_out, sym_out, mon_e.led, mon_e.sym);
        if (led_out !== mon_e.led || sym_out !== mon_e.sym) begin
          tests_failed++;
          $display("FAIL led_symbol: led=%b sym=%0d, required led=%b sym=%0d", led_out, sym_out, mon_e.led, mon_e.sym);
        end
      end
      tests_run++;
      if (gap_cnt !== OFF) begin
        tests_failed++;
        $display("FAIL gap_len: %0d dark cycles, required %0d", gap_cnt, OFF);
      end
      on_cnt = 0;
    end
    if (led_out != 4'd0 && ena_q) on_cnt++;
    if (led_out == 4'd0 && prev_led != 4'd0 && busy === 1'b1) begin
      tests_run++;
      if (on_cnt !== ON) begin
        tests_failed++;
        $display("FAIL on_len: LED lit %0d enabled cycles, required %0d", on_cnt, ON);
      end
    end
    if (led_out == 4'd0 && busy === 1'b1 && ena_q) gap_cnt++;
    else if (led_out != 4'd0 || busy !== 1'b1) gap_cnt = 0;
    prev_led = led_out;
  end

  task automatic apply_reset();
    rst_n = 1'b0; ena = 1'b1; new_game = 1'b0; start = 1'b0;
    seq_len = 6'd0; chk_restart = 1'b0; chk_next = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_seq(input logic [7:0] seed, input int len);
    logic [7:0] x = seed;
    exp_t e;
    for (int k = 0; k < len; k++) begin
      x = m_step(x);
      e.led = 4'b0001 << x[1:0];
      e.sym = x[1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [5:0] len, output int t0);
    start = 1'b1; seq_len = len;
    @(negedge clk);
    start = 1'b0; seq_len = 6'h2A;
    t0 = ncyc;
  endtask

  task automatic wait_done(input int t0, input int budget, output int dt);
    while (done !== 1'b1 && (ncyc - t0) < budget) @(negedge clk);
    dt = ncyc - t0;
  endtask

  task automatic pulse_chk(input logic rs, input logic nx);
    chk_restart = rs; chk_next = nx;
    @(negedge clk);
    chk_restart = 1'b0; chk_next = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({led_out, sym_out, busy, done, exp_sym} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: led=%b sym=%0d busy=%b done=%b exp=%0d, required all 0",
               led_out, sym_out, busy, done, exp_sym);
    end
  endtask

  task automatic test_play_four();
    logic [1:0] tab [4];
    exp_t e;
    int t0, dt;
    tab = '{2'd0, 2'd0, 2'd2, 2'd3};
    for (int k = 0; k < 4; k++) begin
      e.led = 4'b0001 << tab[k];
      e.sym = tab[k];
      exp_q.push_back(e);
    end
    pulse_start(6'd4, t0);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL play4_busy: busy=%b after start edge, required 1", busy);
    end
    wait_done(t0, 200, dt);
    $display("[TB] play4 done after %0d cycles", dt);
    tests_run++;
    if (done !== 1'b1 || dt !== 49 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL play4_done: done=%b at %0d cycles busy=%b, required done=1 at 49 busy=0", done, dt, busy);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL play4_count: %0d symbols never shown, required 0", exp_q.size());
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL play4_pulse: done=%b busy=%b one cycle later, required 0 0", done, busy);
    end
  endtask

  task automatic test_chk_stream();
    logic [1:0] want [4];
    want = '{2'd0, 2'd0, 2'd2, 2'd3};
    for (int i = 0; i < 4; i++) begin
      pulse_chk(i == 0, i != 0);
      $display("[TB] chk step %0d exp_sym=%0d", i, exp_sym);
      tests_run++;
      if (exp_sym !== want[i]) begin
        tests_failed++;
        $display("FAIL chk_stream[%0d]: exp_sym=%0d, required %0d", i, exp_sym, want[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    int t0, dt, bad;
    pulse_start(6'd0, t0);
    wait_done(t0, 20, dt);
    $display("[TB] zero-length done after %0d cycles", dt);
    tests_run++;
    if (done !== 1'b1 || dt !== 1 || led_out !== 4'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_done: done=%b at %0d led=%b busy=%b, required done=1 at 1 led=0 busy=0",
               done, dt, led_out, busy);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || led_out !== 4'd0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL zero_len_after: %0d cycles with busy/done/led active, required 0", bad);
    end
  endtask

  task automatic test_new_game();
    int t0, dt, guard, done_seen;
    push_seq(seed_m, 4);
    pulse_start(6'd4, t0);
    guard = 0;
    while (led_out === 4'd0 && guard < 50) begin @(negedge clk); guard++; end
    tests_run++;
    if (led_out === 4'd0) begin
      tests_failed++;
      $display("FAIL ng_first_led: no LED after %0d cycles, required one lit", guard);
    end
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    exp_q.delete();
    $display("[TB] new_game abort, new seed %h", seed_m);
    tests_run++;
    if (led_out !== 4'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ng_abort: led=%b busy=%b, required 0 0", led_out, busy);
    end
    done_seen = 0;
    repeat (60) begin @(negedge clk); if (done === 1'b1) done_seen++; end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL ng_no_done: done seen %0d times, required 0", done_seen);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_chk(i == 0, i != 0);
      tests_run++;
      if (exp_sym !== sym_at(seed_m, i)) begin
        tests_failed++;
        $display("FAIL ng_chk[%0d]: exp_sym=%0d, required %0d", i, exp_sym, sym_at(seed_m, i));
      end
    end
    push_seq(seed_m, 5);
    pulse_start(6'd5, t0);
    wait_done(t0, 200, dt);
    tests_run++;
    if (done !== 1'b1 || dt !== 61 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL ng_replay: done=%b at %0d with %0d left, required done=1 at 61 with 0 left",
               done, dt, exp_q.size());
    end
    @(negedge clk);
    new_game = 1'b1; start = 1'b1; seq_len = 6'd3;
    @(negedge clk);
    new_game = 1'b0; start = 1'b0;
    done_seen = 0;
    repeat (20) begin @(negedge clk); if (busy !== 1'b0 || done !== 1'b0) done_seen++; end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL ng_over_start: %0d cycles busy/done after new_game+start, required 0", done_seen);
    end
  endtask

  task automatic test_ena_hold();
    int t0, dt, guard, bad;
    logic [3:0] hold;
    push_seq(seed_m, 2);
    pulse_start(6'd2, t0);
    guard = 0;
    while (led_out === 4'd0 && guard < 50) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    hold = led_out;
    ena = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      @(negedge clk);
      if (led_out !== hold || hold === 4'd0) bad++;
    end
    ena = 1'b1;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ena_hold: led changed/dark in %0d disabled cycles (held %b), required 0", bad, hold);
    end
    guard = 0;
    while (led_out !== 4'd0 && guard < 50) begin @(negedge clk); guard++; end
    start = 1'b1; seq_len = 6'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, 200, dt);
    $display("[TB] ena-hold done after %0d cycles", dt);
    tests_run++;
    if (done !== 1'b1 || dt !== 35) begin
      tests_failed++;
      $display("FAIL ena_done: done=%b at %0d cycles, required done=1 at 35", done, dt);
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL ena_ignored_start: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_chk_both_and_reset();
    int t0, done_seen;
    apply_reset();
    pulse_chk(1'b1, 1'b0);
    pulse_chk(1'b0, 1'b1);
    pulse_chk(1'b0, 1'b1);
    tests_run++;
    if (exp_sym !== sym_at(8'h01, 2)) begin
      tests_failed++;
      $display("FAIL chk_sym2: exp_sym=%0d, required %0d", exp_sym, sym_at(8'h01, 2));
    end
    pulse_chk(1'b1, 1'b1);
    tests_run++;
    if (exp_sym !== sym_at(8'h01, 0)) begin
      tests_failed++;
      $display("FAIL chk_both: exp_sym=%0d, required %0d", exp_sym, sym_at(8'h01, 0));
    end
    pulse_chk(1'b0, 1'b1);
    pulse_chk(1'b0, 1'b1);
    push_seq(seed_m, 3);
    pulse_start(6'd3, t0);
    repeat (30) @(negedge clk);
    tests_run++;
    if (led_out !== 4'b0100 || sym_out !== 2'd2 || exp_sym !== 2'd2) begin
      tests_failed++;
      $display("FAIL pre_reset: led=%b sym=%0d exp=%0d, required 0100 2 2", led_out, sym_out, exp_sym);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    tests_run++;
    if ({led_out, sym_out, busy, done, exp_sym} !== 10'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: led=%b sym=%0d busy=%b done=%b exp=%0d, required all 0",
               led_out, sym_out, busy, done, exp_sym);
    end
    done_seen = 0;
    repeat (60) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) done_seen++; end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_quiet: %0d cycles busy/done after reset, required 0", done_seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; new_game = 1'b0; start = 1'b0;
    seq_len = 6'd0; chk_restart = 1'b0; chk_next = 1'b0;
    test_reset();
    test_play_four();
    test_chk_stream();
    test_zero_len();
    test_new_game();
    test_ena_hold();
    test_chk_both_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
